// File: rtl/div_lzskip.sv
// div_lzskip: multi-cycle DIV/DIVU that skips leading dividend zeros using an external clz count
module div_lzskip #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [5:0]       dividend_clz,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_zero
);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t state;
  logic [5:0] k, clz_sat, k_in;
  logic [WIDTH-1:0] sh, rem, qt, dvs, a_raw, abs_a, abs_b, qf, rf;
  logic neg_a, neg_b, dz, neg_a_in, neg_b_in, ge;
  logic [WIDTH:0] t, diff;
  always_comb begin
    neg_a_in = is_signed & dividend[WIDTH-1];
    neg_b_in = is_signed & divisor[WIDTH-1];
    abs_a = neg_a_in ? -dividend : dividend;
    abs_b = neg_b_in ? -divisor : divisor;
    clz_sat = dividend_clz > 6'd32 ? 6'd32 : dividend_clz;
    k_in = 6'd32 - clz_sat;
    // 33-bit trial keeps the compare exact for unsigned divisors above 2^31
    t = {rem, sh[WIDTH-1]};
    diff = t - {1'b0, dvs};
    ge = t >= {1'b0, dvs};
    qf = (neg_a ^ neg_b) ? -qt : qt;
    rf = neg_a ? -rem : rem;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      q <= '0;
      r <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          neg_a <= neg_a_in;
          neg_b <= neg_b_in;
          dvs <= abs_b;
          a_raw <= dividend;
          dz <= divisor == '0;
          k <= k_in;
          sh <= abs_a << clz_sat;
          rem <= '0;
          qt <= '0;
          busy <= 1'b1;
          state <= (k_in != 6'd0 && divisor != '0) ? RUN : FIX;
        end
        RUN: begin
          rem <= ge ? diff[WIDTH-1:0] : t[WIDTH-1:0];
          sh <= sh << 1;
          qt <= {qt[WIDTH-2:0], ge};
          k <= k - 6'd1;
          state <= k == 6'd1 ? FIX : RUN;
        end
        FIX: begin
          q <= dz ? '1 : qf;
          r <= dz ? a_raw : rf;
          div_zero <= dz;
          busy <= 1'b0;
          done <= 1'b1;
          state <= DONE;
        end
        default: begin
          done <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_div_lzskip.sv
// tb_div_lzskip: vector table plus scoreboard queue for div_lzskip results and latency
module tb_div_lzskip;
  logic clk = 0, reset = 1, start = 0, is_signed = 0;
  logic [31:0] dividend = 0, divisor = 0;
  logic [5:0] dividend_clz = 0;
  logic busy, done, div_zero;
  logic [31:0] q, r;
  int total = 0, bad = 0;

  div_lzskip dut (.clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .dividend_clz(dividend_clz),
    .busy(busy), .done(done), .q(q), .r(r), .div_zero(div_zero));

  always #5 clk = ~clk;

  typedef struct {logic sg; logic [31:0] a, b; logic [5:0] clz; logic [31:0] eq, er; logic edz;} vec_t;
  typedef struct {logic [31:0] q, r; logic dz; int lat;} exp_t;
  exp_t sb[$];
  vec_t vt[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input int spur);
    exp_t e;
    int cyc, busy_cnt, extra;
    @(negedge clk);
    is_signed = v.sg; dividend = v.a; divisor = v.b; dividend_clz = v.clz; start = 1;
    e.q = v.eq; e.r = v.er; e.dz = v.edz;
    e.lat = (v.b == 0) ? 2 : 32 - ((v.clz > 32) ? 32 : int'(v.clz)) + 2;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 0; dividend = 32'hDEADBEEF; divisor = 32'h0; dividend_clz = 6'd7;
    cyc = 1; busy_cnt = 0;
    while (!done && cyc < 40) begin
      if (busy) busy_cnt++;
      start = (cyc == spur);
      @(posedge clk); #1;
      cyc++;
    end
    start = 0;
    if (!done) begin
      total++; bad++;
      $display("FAIL timeout: no done after %0d cycles", cyc);
      sb.delete();
      return;
    end
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard: done with empty queue");
      return;
    end
    e = sb.pop_front();
    chk("latency", cyc, e.lat);
    chk("busy_cycles", busy_cnt, e.lat - 1);
    chk("busy_at_done", {31'b0, busy}, 0);
    chk("q", q, e.q);
    chk("r", r, e.r);
    chk("div_zero", {31'b0, div_zero}, {31'b0, e.dz});
    // start held in the DONE cycle must be ignored
    start = 1; dividend = 32'd9; divisor = 32'd3; dividend_clz = 6'd28;
    @(posedge clk); #1;
    start = 0;
    chk("start_in_done_ignored", {30'b0, busy, done}, 0);
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    chk("no_extra_activity", extra, 0);
  endtask

  initial begin
    vt[0]  = '{0, 32'd100, 32'd7, 6'd25, 32'd14, 32'd2, 0};
    vt[1]  = '{1, 32'hFFFFFFF9, 32'd2, 6'd29, 32'hFFFFFFFD, 32'hFFFFFFFF, 0};
    vt[2]  = '{0, 32'hFFFFFFFF, 32'd1, 6'd0, 32'hFFFFFFFF, 32'd0, 0};
    vt[3]  = '{0, 32'd5, 32'd0, 6'd29, 32'hFFFFFFFF, 32'd5, 1};
    vt[4]  = '{0, 32'd0, 32'd3, 6'd32, 32'd0, 32'd0, 0};
    vt[5]  = '{1, 32'h80000000, 32'hFFFFFFFF, 6'd0, 32'h80000000, 32'd0, 0};
    vt[6]  = '{0, 32'd1000, 32'd33, 6'd22, 32'd30, 32'd10, 0};
    vt[7]  = '{1, 32'hFFFFFF9C, 32'd7, 6'd25, 32'hFFFFFFF2, 32'hFFFFFFFE, 0};
    vt[8]  = '{1, 32'd100, 32'hFFFFFFF9, 6'd25, 32'hFFFFFFF2, 32'd2, 0};
    vt[9]  = '{0, 32'hFFFFFFFF, 32'hFFFFFFFE, 6'd0, 32'd1, 32'd1, 0};
    vt[10] = '{0, 32'd7, 32'd9, 6'd29, 32'd0, 32'd7, 0};
    vt[11] = '{0, 32'd0, 32'd5, 6'd40, 32'd0, 32'd0, 0};
    vt[12] = '{1, 32'hFFFFFFF9, 32'd0, 6'd29, 32'hFFFFFFFF, 32'hFFFFFFF9, 1};

    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("reset_outputs", {busy, done, div_zero}, 0);
    chk("reset_q", q, 0);
    chk("reset_r", r, 0);

    for (int i = 0; i < 13; i++) run_op(vt[i], (i == 2) ? 10 : -1);

    // reset in cycle 4 of a running 100/7, then a fresh start in cycle 5
    @(negedge clk);
    is_signed = 0; dividend = 100; divisor = 7; dividend_clz = 25; start = 1;
    @(posedge clk); #1;
    start = 0;
    begin
      int pulses = 0;
      for (int c = 1; c <= 4; c++) begin
        reset = (c == 4);
        if (done) pulses++;
        @(posedge clk); #1;
      end
      reset = 0;
      if (done) pulses++;
      chk("reset_abort_no_done", pulses, 0);
    end
    chk("reset_abort_busy", {31'b0, busy}, 0);
    chk("reset_abort_q", q, 0);
    chk("reset_abort_r", r, 0);
    run_op(vt[0], -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
